// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: pixel source for the 1024x768@60 VGA timing block.
// Tracks the active-pixel position from the RGB-enable strobe and emits one
// registered 24-bit RGB word per enabled cycle, chosen from four test
// patterns (colour bars, checkerboard, grey ramp, bouncing box).
module vga_pattern_gen #(
   parameter int H_ACT = 1024,   // active pixels per line (multiple of 8)
   parameter int V_ACT = 768,    // active lines per frame
   parameter int BOX   = 64,     // bouncing-box edge length
   parameter int STEP  = 4       // box displacement per frame per axis
) (
   input  logic        VGA_CLK,
   input  logic        VGA_RST_N,
   input  logic        VGA_VSYNC,
   input  logic        VGA_IF_RGBEN,
   input  logic [1:0]  MODE,
   output logic [23:0] VGA_BUF_RGB,
   output logic        FRAME_TICK
);

   typedef enum logic [1:0] {
      MODE_BARS  = 2'd0,
      MODE_CHECK = 2'd1,
      MODE_GREY  = 2'd2,
      MODE_BOX   = 2'd3
   } mode_e;

   // One bouncing-box axis: position and direction (0 = increasing).
   typedef struct packed {
      logic [10:0] pos;
      logic        dir;
   } axis_t;

   localparam logic [10:0] X_LAST   = 11'(H_ACT - 1);
   localparam logic [10:0] Y_LAST   = 11'(V_ACT - 1);
   localparam logic [10:0] BAR_LAST = 11'(H_ACT / 8 - 1);
   localparam logic [11:0] BX_MAX   = 12'(H_ACT - BOX);
   localparam logic [11:0] BY_MAX   = 12'(V_ACT - BOX);
   localparam logic [11:0] STEP_W   = 12'(STEP);
   localparam logic [11:0] BOX_W    = 12'(BOX);

   localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
   localparam logic [23:0] RGB_BLACK = 24'h000000;
   localparam logic [23:0] RGB_BLUE  = 24'h0000FF;

   // Position and bar tracking
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic [10:0] bar_cnt_q, bar_cnt_d;
   logic [2:0]  bar_idx_q, bar_idx_d;

   // Frame-rate state
   mode_e       mode_q, mode_d;
   axis_t       box_x_q, box_x_d;
   axis_t       box_y_q, box_y_d;

   // Output registers
   logic [23:0] rgb_q, rgb_d;
   logic        tick_q, tick_d;

   logic        line_end;
   logic        frame_end;
   logic        in_box;
   logic [23:0] pixel;

   // Advance one step along an axis, bouncing at 0 and at lim without wrap.
   function automatic axis_t step_axis(input axis_t a, input logic [11:0] lim);
      axis_t r;
      r = a;
      if (!a.dir) begin
         if ({1'b0, a.pos} + STEP_W >= lim) begin
            r.pos = lim[10:0];
            r.dir = 1'b1;
         end else begin
            r.pos = a.pos + STEP_W[10:0];
         end
      end else begin
         if ({1'b0, a.pos} <= STEP_W) begin
            r.pos = '0;
            r.dir = 1'b0;
         end else begin
            r.pos = a.pos - STEP_W[10:0];
         end
      end
      return r;
   endfunction

   // Colour for a given bar index, left to right.
   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = 24'hFFFFFF;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FFFF;
         3'd3:    c = 24'h00FF00;
         3'd4:    c = 24'hFF00FF;
         3'd5:    c = 24'hFF0000;
         3'd6:    c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

   assign line_end  = VGA_IF_RGBEN && (x_q == X_LAST);
   assign frame_end = line_end && (y_q == Y_LAST);

   // Position, bar counter and resync: VSYNC low beats RGBEN counting.
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
      x_d       = x_q;
      y_d       = y_q;
      bar_cnt_d = bar_cnt_q;
      bar_idx_d = bar_idx_q;
      if (!VGA_VSYNC) begin
         x_d       = '0;
         y_d       = '0;
         bar_cnt_d = '0;
         bar_idx_d = '0;
      end else if (VGA_IF_RGBEN) begin
         if (line_end) begin
            x_d       = '0;
            bar_cnt_d = '0;
            bar_idx_d = '0;
            y_d       = (y_q == Y_LAST) ? 11'd0 : y_q + 11'd1;
         end else begin
            x_d = x_q + 11'd1;
            if (bar_cnt_q == BAR_LAST) begin
               bar_cnt_d = '0;
               bar_idx_d = bar_idx_q + 3'd1;
            end else begin
               bar_cnt_d = bar_cnt_q + 11'd1;
            end
         end
      end
   end

   // Mode latch and box motion: only at frame end (mode also while VSYNC low).
   always_comb begin
      mode_d  = mode_q;
      box_x_d = box_x_q;
      box_y_d = box_y_q;
      if (frame_end || !VGA_VSYNC) begin
         mode_d = mode_e'(MODE);
      end
      if (frame_end) begin
         box_x_d = step_axis(box_x_q, BX_MAX);
         box_y_d = step_axis(box_y_q, BY_MAX);
      end
   end

   // Pattern selection for the current (X,Y); box uses start-of-frame position.
   always_comb begin
      in_box = (x_q >= box_x_q.pos) && ({1'b0, x_q} < {1'b0, box_x_q.pos} + BOX_W) &&
               (y_q >= box_y_q.pos) && ({1'b0, y_q} < {1'b0, box_y_q.pos} + BOX_W);
      case (mode_q)
         MODE_BARS:  pixel = bar_colour(bar_idx_q);
         MODE_CHECK: pixel = (x_q[5] ^ y_q[5]) ? RGB_BLACK : RGB_WHITE;
         MODE_GREY:  pixel = {3{x_q[9:2]}};
         default:    pixel = in_box ? RGB_WHITE : RGB_BLUE;
      endcase
      rgb_d  = VGA_IF_RGBEN ? pixel : RGB_BLACK;
      tick_d = frame_end;
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
      if (!VGA_RST_N) begin
         x_q       <= '0;
         y_q       <= '0;
         bar_cnt_q <= '0;
         bar_idx_q <= '0;
         mode_q    <= MODE_BARS;
         box_x_q   <= '0;
         box_y_q   <= '0;
         rgb_q     <= '0;
         tick_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         x_q       <= x_d;
         y_q       <= y_d;
         bar_cnt_q <= bar_cnt_d;
         bar_idx_q <= bar_idx_d;
         mode_q    <= mode_d;
         box_x_q   <= box_x_d;
         box_y_q   <= box_y_d;
         rgb_q     <= rgb_d;
         tick_q    <= tick_d;
      end
   end

   assign VGA_BUF_RGB = rgb_q;
   assign FRAME_TICK  = tick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: a full-size instance for line-level patterns and
// a shrunken instance (32x16, box 4, step 3) for frame-level behaviour.
module tb_vga_pattern_gen;

   localparam int SH    = 32;
   localparam int SV    = 16;
   localparam int SBOX  = 4;
   localparam int SSTEP = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;

   logic        vs_b   = 1'b1;
   logic        en_b   = 1'b0;
   logic [1:0]  mode_b = 2'd0;
   logic [23:0] rgb_b;
   logic        tick_b;

   logic        vs_s   = 1'b1;
   logic        en_s   = 1'b0;
   logic [1:0]  mode_s = 2'd0;
   logic [23:0] rgb_s;
   logic        tick_s;

   int checks = 0;
   int errors = 0;

   logic [23:0] bar_col [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   // Small-instance box model and last captured frame
   int          m_bx = 0, m_by = 0;
   bit          m_dx = 0, m_dy = 0;
   logic [23:0] img [SV][SH];

   vga_pattern_gen dut (
      .VGA_CLK      (clk),
      .VGA_RST_N    (rst_n),
      .VGA_VSYNC    (vs_b),
      .VGA_IF_RGBEN (en_b),
      .MODE         (mode_b),
      .VGA_BUF_RGB  (rgb_b),
      .FRAME_TICK   (tick_b)
   );

   vga_pattern_gen #(.H_ACT(SH), .V_ACT(SV), .BOX(SBOX), .STEP(SSTEP)) dut_s (
      .VGA_CLK      (clk),
      .VGA_RST_N    (rst_n),
      .VGA_VSYNC    (vs_s),
      .VGA_IF_RGBEN (en_s),
      .MODE         (mode_s),
      .VGA_BUF_RGB  (rgb_s),
      .FRAME_TICK   (tick_s)
   );

   always #5 clk = ~clk;

   // One cycle on the full-size instance, checking the registered result.
   task automatic drive_b(input logic en, input logic vs, input logic [23:0] exp, input string name);
      @(negedge clk);
      en_b = en;
      vs_b = vs;
      @(posedge clk);
      #1;
      checks++;
      if (rgb_b !== exp) begin
         errors++;
         $display("FAIL %s: rgb=%06h expected %06h", name, rgb_b, exp);
      end
   endtask

   // One cycle on the small instance, checking RGB and FRAME_TICK.
   task automatic drive_s(input logic en, input logic vs, input logic [23:0] exp,
                          input logic exp_tick, input string name, output logic [23:0] got);
      @(negedge clk);
      en_s = en;
      vs_s = vs;
      @(posedge clk);
      #1;
      got = rgb_s;
      checks++;
      if (rgb_s !== exp) begin
         errors++;
         $display("FAIL %s: rgb=%06h expected %06h", name, rgb_s, exp);
      end
      checks++;
      if (tick_s !== exp_tick) begin
         errors++;
         $display("FAIL %s_tick: tick=%0b expected %0b", name, tick_s, exp_tick);
      end
   endtask

   task automatic model_step(inout int p, inout bit d, input int lim);
      if (!d) begin
         if (p + SSTEP >= lim) begin p = lim; d = 1'b1; end
         else p = p + SSTEP;
      end else begin
         if (p <= SSTEP) begin p = 0; d = 1'b0; end
         else p = p - SSTEP;
      end
   endtask

   // Drive one whole small frame; switch MODE to 3 at index sw (if >= 0).
   task automatic run_frame_s(input bit box_mode, input bit vs_end, input int sw, input string name);
      logic [23:0] exp, got;
      for (int y = 0; y < SV; y++) begin
         for (int x = 0; x < SH; x++) begin
            bit last;
            last = (x == SH - 1) && (y == SV - 1);
            if (sw >= 0 && y * SH + x == sw) mode_s = 2'd3;
            if (box_mode)
               exp = (x >= m_bx && x < m_bx + SBOX && y >= m_by && y < m_by + SBOX) ? 24'hFFFFFF : 24'h0000FF;
            else
               exp = bar_col[x / (SH / 8)];
            drive_s(1'b1, !(vs_end && last), exp, last, $sformatf("%s_x%0d_y%0d", name, x, y), got);
            img[y][x] = got;
         end
      end
      model_step(m_bx, m_dx, SH - SBOX);
      model_step(m_by, m_dy, SV - SBOX);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #20;
      checks += 4;
      if (rgb_b !== 24'h0)  begin errors++; $display("FAIL reset_rgb: rgb=%06h expected 000000", rgb_b); end
      if (tick_b !== 1'b0)  begin errors++; $display("FAIL reset_tick: tick=%0b expected 0", tick_b); end
      if (rgb_s !== 24'h0)  begin errors++; $display("FAIL reset_rgb_s: rgb=%06h expected 000000", rgb_s); end
      if (tick_s !== 1'b0)  begin errors++; $display("FAIL reset_tick_s: tick=%0b expected 0", tick_s); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_bars();
      for (int i = 0; i < 1024; i++) begin
         drive_b(1'b1, 1'b1, bar_col[i / 128], $sformatf("bars_x%0d", i));
         if (i == 300)
            for (int g = 0; g < 5; g++) drive_b(1'b0, 1'b1, 24'h000000, "bars_gap");
      end
   endtask

   // Resync into checkerboard; check lines 0..32 (squares flip at 32).
   task automatic test_checker();
      logic [10:0] xv, yv;
      mode_b = 2'd1;
      drive_b(1'b0, 1'b0, 24'h000000, "checker_vsync");
      for (int y = 0; y <= 32; y++) begin
         for (int x = 0; x < 1024; x++) begin
            xv = 11'(x);
            yv = 11'(y);
            drive_b(1'b1, 1'b1, (xv[5] ^ yv[5]) ? 24'h000000 : 24'hFFFFFF, $sformatf("checker_x%0d_y%0d", x, y));
         end
      end
   endtask

   // VSYNC low mid-line at (200,33): next pixel must come from (0,0).
   task automatic test_vsync();
      logic [10:0] xv;
      for (int x = 0; x < 200; x++) begin
         xv = 11'(x);
         drive_b(1'b1, 1'b1, xv[5] ? 24'hFFFFFF : 24'h000000, "vsync_pre");
      end
      drive_b(1'b0, 1'b0, 24'h000000, "vsync_low0");
      drive_b(1'b0, 1'b0, 24'h000000, "vsync_low1");
      drive_b(1'b1, 1'b1, 24'hFFFFFF, "vsync_first_pixel");
      for (int x = 1; x < 1024; x++) begin
         xv = 11'(x);
         drive_b(1'b1, 1'b1, xv[5] ? 24'h000000 : 24'hFFFFFF, $sformatf("vsync_post_x%0d", x));
      end
   endtask

   // Grey ramp; a mid-line MODE change must not take effect.
   task automatic test_grey();
      logic [10:0] xv;
      mode_b = 2'd2;
      drive_b(1'b0, 1'b0, 24'h000000, "grey_vsync");
      for (int x = 0; x < 1024; x++) begin
         xv = 11'(x);
         if (x == 512) mode_b = 2'd0;
         drive_b(1'b1, 1'b1, {3{xv[9:2]}}, $sformatf("grey_x%0d", x));
      end
      drive_b(1'b0, 1'b1, 24'h000000, "grey_idle");
   endtask

   task automatic test_frames();
      mode_s = 2'd0;
      run_frame_s(1'b0, 1'b0, 9 * SH + 16, "mode_change_bars");
      for (int f = 1; f <= 20; f++) begin
         run_frame_s(1'b1, 1'b0, -1, $sformatf("box_f%0d", f));
         if (f == 10) begin
            checks += 4;
            if (img[6][28] !== 24'hFFFFFF) begin errors++; $display("FAIL box_f10_corner: rgb=%06h expected FFFFFF", img[6][28]); end
            if (img[6][27] !== 24'h0000FF) begin errors++; $display("FAIL box_f10_left: rgb=%06h expected 0000FF", img[6][27]); end
            if (img[9][31] !== 24'hFFFFFF) begin errors++; $display("FAIL box_f10_far: rgb=%06h expected FFFFFF", img[9][31]); end
            if (img[10][28] !== 24'h0000FF) begin errors++; $display("FAIL box_f10_below: rgb=%06h expected 0000FF", img[10][28]); end
         end
         if (f == 20) begin
            checks += 4;
            if (img[15][0] !== 24'hFFFFFF) begin errors++; $display("FAIL box_f20_corner: rgb=%06h expected FFFFFF", img[15][0]); end
            if (img[15][3] !== 24'hFFFFFF) begin errors++; $display("FAIL box_f20_edge: rgb=%06h expected FFFFFF", img[15][3]); end
            if (img[15][4] !== 24'h0000FF) begin errors++; $display("FAIL box_f20_right: rgb=%06h expected 0000FF", img[15][4]); end
            if (img[11][0] !== 24'h0000FF) begin errors++; $display("FAIL box_f20_above: rgb=%06h expected 0000FF", img[11][0]); end
         end
      end
      // Frame end coinciding with VSYNC low: one tick, one box update.
      run_frame_s(1'b1, 1'b1, -1, "box_vs_end");
      run_frame_s(1'b1, 1'b0, -1, "box_after_vs");
   endtask

   // Asynchronous reset mid-line, then restart at (0,0) with bars.
   task automatic test_reset_mid();
      logic [10:0] xv;
      mode_b = 2'd2;
      drive_b(1'b0, 1'b0, 24'h000000, "rmid_vsync");
      for (int x = 0; x < 500; x++) begin
         xv = 11'(x);
         drive_b(1'b1, 1'b1, {3{xv[9:2]}}, "rmid_grey");
      end
      en_b = 1'b0;
      mode_b = 2'd1;
      #2 rst_n = 1'b0;
      #1;
      checks += 2;
      if (rgb_b !== 24'h0) begin errors++; $display("FAIL reset_mid_rgb: rgb=%06h expected 000000", rgb_b); end
      if (tick_b !== 1'b0) begin errors++; $display("FAIL reset_mid_tick: tick=%0b expected 0", tick_b); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int x = 0; x <= 128; x++)
         drive_b(1'b1, 1'b1, bar_col[x / 128], $sformatf("after_reset_x%0d", x));
   endtask

   initial begin
      test_reset();
      test_bars();
      test_checker();
      test_vsync();
      test_grey();
      test_frames();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
